// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider, signed/unsigned, {rem, quo} result; DIV_ZERO_FAST_EN skips iteration on zero divisor
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    input  logic        opn_valid,
    input  logic        res_ready,
    output logic        res_valid,
    output logic [63:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dvs, abs_a, rem_nx, quo_nx;
    logic [32:0] shf, t;
    logic        neg_q, neg_r, last, zero_fast;
`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = b == 32'd0;
`else
    assign zero_fast = 1'b0;
`endif
    assign abs_a  = sign & a[31] ? -a : a;
    // the shifted-in partial remainder is 33 bits wide so divisors above 2^31 still compare correctly
    assign shf    = {rem, quo[31]};
    assign t      = shf - {1'b0, dvs};
    assign rem_nx = t[32] ? shf[31:0] : t[31:0];
    assign quo_nx = {quo[30:0], ~t[32]};
    assign last   = cnt == 6'd31;
    assign res_valid = state == DONE;
    assign busy      = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: dropping opn_valid cancels from BUSY or DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = opn_valid ? (zero_fast ? DONE : BUSY) : IDLE;
            BUSY:    state_nx = !opn_valid ? IDLE : last ? DONE : BUSY;
            DONE:    state_nx = !opn_valid || res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // operand capture, one quotient bit per cycle, sign fix-up into the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (state == IDLE) begin
            if (opn_valid) begin
                dvs   <= sign & b[31] ? -b : b;
                neg_q <= sign & (a[31] ^ b[31]);
                neg_r <= sign & a[31];
                cnt   <= '0;
                rem   <= '0;
                quo   <= abs_a;
                if (zero_fast) result <= {a, sign & a[31] ? 32'd1 : 32'hFFFF_FFFF};
            end
        end else if (!opn_valid) begin
            result <= '0;
        end else if (state == BUSY) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 6'd1;
            if (last) result <= {neg_r ? -rem_nx : rem_nx, neg_q ? -quo_nx : quo_nx};
        end
    end
endmodule
